pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Measures an external PWM waveform; the receive-side counterpart of the PWM generators.
- Synchronizes pwm_i and detects edges.
- Counts prescaled ticks to report period and high time for each completed cycle.
- Flags a stuck line (0 % / 100 % duty, or no signal) via a programmable timeout.
- Sits in the PWM peripheral next to the generator channels; results are read by the register interface.

Parameters:
- Resolution, 16, width of the counters, step, timeout and result fields.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  capture enable; low forces IDLE
- step_i  in  Resolution  prescaler; one tick every step_i+1 clocks
- timeout_i  in  Resolution  stuck threshold in ticks; 0 disables the timeout
- pwm_i  in  1  asynchronous PWM input
- period_o  out  Resolution  last measured period, in ticks
- high_o  out  Resolution  last measured high time, in ticks
- valid_o  out  1  one-cycle pulse; period_o/high_o updated
- overflow_o  out  1  last result saturated
- stuck_o  out  1  line static for at least timeout_i ticks
- stuck_level_o  out  1  level of the stuck line

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- Input path: 2-FF synchronizer, then a previous-sample register.
  - rise = s & ~prev; fall = ~s & prev.
- Prescaler/counter (single counter cnt, single prescaler presc):
  - On rise: presc<=0, cnt<=0.
  - Otherwise: if presc==step_i then presc<=0 and cnt<=sat(cnt+1); else presc<=presc+1.
- Saturation: cnt and the captured value cnt+1 both saturate at all-ones. Saturation sets an internal ovf bit, cleared on rise.
- FSM states and transitions:
  - IDLE: wait for rise, go to HIGH; no result produced.
  - HIGH: on fall, h<=sat(cnt+1), go to LOW.
  - LOW: on rise, period_o<=sat(cnt+1), high_o<=h, overflow_o<=ovf, valid_o<=1, stuck_o<=0, go to HIGH.
- Resulting values:
  - period_o = ceil(cycles/(step_i+1)).
  - high_o = ceil(high cycles/(step_i+1)).
- Latency: valid_o asserts on the 3rd rising clk_i edge after the edge that first samples pwm_i high (sync 2 + register 1).
- Timeout: when timeout_i!=0 and cnt==timeout_i in any state:
  - stuck_o<=1, stuck_level_o<=s.
  - period_o<=0, high_o<=0, state<=IDLE.
  - No valid_o pulse.
  - stuck_o clears on the next valid_o or when enable_i is low.
- enable_i low: state IDLE, cnt/presc held at 0, stuck_o<=0; period_o/high_o/overflow_o hold.
- Mid-period step_i change: takes effect at the next presc compare. The mixed-unit result is reported without a flag.
- Same-cycle events:
  - A rise and a tick in the same cycle: the rise wins and the tick is discarded.
  - A rise and the timeout in the same cycle: the rise wins.
- Rise seen in HIGH (fall missed, glitch): treat as period end with high_o = sat(cnt+1) and overflow_o as per ovf.
- Reset mid-measurement: the partial result is discarded and no valid_o pulse occurs.

Optional Feature:
- Macro PWM_CAPTURE_FILTER_EN.
- Defined: a glitch filter follows the synchronizer. s changes only after 3 consecutive identical synchronized samples. Latency becomes 5 edges; pulses shorter than 3 clocks are ignored.
- Undefined: s is the synchronizer output directly; latency 3 edges.

Decomposition:
- Shared PWM package holds:
  - FSM state encoding (IDLE/HIGH/LOW).
  - Synchronizer depth constant 2.
  - Filter length constant 3.
  - Saturating-increment function.
- One sub-module: pwm_capture_sync, containing the synchronizer, optional filter and edge detector, with outputs s/rise/fall. Counters and FSM stay in pwm_capture.

Test Plan:
- step_i=0, timeout_i=0, pwm_i period 10 clk, high 3 clk, 4 cycles -> from the 2nd rise on, valid_o once per period, period_o=10, high_o=3, overflow_o=0.
- step_i=1, period 10 clk, high 4 clk -> period_o=5, high_o=2.
- Resolution=4, step_i=0, period 40 clk, high 20 clk -> period_o=15, high_o=15, overflow_o=1.
- timeout_i=20, step_i=0, pwm_i held high after one rise -> stuck_o=1 and stuck_level_o=1 about 20 clk later, period_o=0, no valid_o. Resume 10/3 waveform -> stuck_o clears at the first valid_o.
- enable_i dropped mid-high, raised again, 10/3 waveform -> no valid_o until the 2nd rise after re-enable, then period_o=10. Also rst_i mid-period -> all outputs 0, no valid_o.
- With PWM_CAPTURE_FILTER_EN, a 2-clk glitch injected in the low phase -> ignored, period_o=10. Without the macro, the same glitch yields a spurious valid_o.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared state encoding, pipeline constants and saturating helper for PWM capture.
package pwm_capture_pkg;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} cap_state_e;

   localparam int SYNC_DEPTH = 2;
   localparam int FILTER_LEN = 3;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: input synchronizer, glitch filter (PWM_CAPTURE_FILTER_EN) and edge detector.
// The filter only lets s follow the line after FILTER_LEN identical synchronized samples.
module pwm_capture_sync
   import pwm_capture_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic pwm_i,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  synced;
   logic                  prev;

   assign synced = sync_q[SYNC_DEPTH-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], pwm_i};
         prev   <= s;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   logic [FILTER_LEN-2:0] hist;
   logic [FILTER_LEN-1:0] win;

   assign win = {hist, synced};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist <= '0;
         s    <= 1'b0;
      end else begin
         hist <= win[FILTER_LEN-2:0];
         s    <= &win ? 1'b1 : ~|win ? 1'b0 : s;
      end
   end
`else
   always_ff @(posedge clk_i) begin
      if (rst_i)
         s <= 1'b0;
      else
         s <= synced;
   end
`endif

   assign rise = s & ~prev;
   assign fall = ~s & prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM line in prescaled ticks.
// Flags a static line via a programmable timeout; optional input glitch filter under PWM_CAPTURE_FILTER_EN.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int Resolution = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic [Resolution-1:0] step_i,
   input  logic [Resolution-1:0] timeout_i,
   input  logic                  pwm_i,
   output logic [Resolution-1:0] period_o,
   output logic [Resolution-1:0] high_o,
   output logic                  valid_o,
   output logic                  overflow_o,
   output logic                  stuck_o,
   output logic                  stuck_level_o
);

   localparam logic [Resolution-1:0] ONES = '1;

   logic                  s, rise, fall;
   cap_state_e            state;
   logic [Resolution-1:0] cnt, presc, h, cnt_inc;
   logic                  ovf, cnt_max, tick, timeout_hit;

   pwm_capture_sync u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .pwm_i (pwm_i),
      .s     (s),
      .rise  (rise),
      .fall  (fall)
   );

   assign cnt_max     = cnt == ONES;
   assign cnt_inc     = Resolution'(sat_inc(32'(cnt), 32'(ONES)));
   assign tick        = presc == step_i;
   assign timeout_hit = (timeout_i != '0) && (cnt == timeout_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         cnt           <= '0;
         presc         <= '0;
         h             <= '0;
         ovf           <= 1'b0;
         period_o      <= '0;
         high_o        <= '0;
         valid_o       <= 1'b0;
         overflow_o    <= 1'b0;
         stuck_o       <= 1'b0;
         stuck_level_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (!enable_i) begin
            state   <= IDLE;
            cnt     <= '0;
            presc   <= '0;
            ovf     <= 1'b0;
            stuck_o <= 1'b0;
         end else if (rise) begin
            // a rise in HIGH means the fall was missed: the whole period counts as high
            cnt   <= '0;
            presc <= '0;
            ovf   <= 1'b0;
            state <= HIGH;
            if (state != IDLE) begin
               period_o   <= cnt_inc;
               high_o     <= (state == HIGH) ? cnt_inc : h;
               overflow_o <= ovf | cnt_max;
               valid_o    <= 1'b1;
               stuck_o    <= 1'b0;
            end
         end else begin
            if (tick) begin
               presc <= '0;
               cnt   <= cnt_inc;
               ovf   <= ovf | cnt_max;
            end else begin
               presc <= presc + Resolution'(1);
            end
            if (timeout_hit) begin
               stuck_o       <= 1'b1;
               stuck_level_o <= s;
               period_o      <= '0;
               high_o        <= '0;
               state         <= IDLE;
            end else if (fall && state == HIGH) begin
               h     <= cnt_inc;
               state <= LOW;
            end
         end
      end
   end

endmodule
